// File: rtl/sys_defs.sv
// Shared definitions for the multiply functional unit.
//   XLEN / TAG_W        : default operand and tag widths carried by the packets
//   MULT_FUNC           : RV32M multiply function select
//   MULT_STAGE_PACKET   : contents of one pipeline stage register
//   MULT_RESULT_PACKET  : completed result presented to CDB arbitration
//   extend_a / extend_b : operand extension to 2*XLEN bits by function
package sys_defs;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 6;

  typedef enum logic [1:0] {
    MULT_MUL    = 2'b00,
    MULT_MULH   = 2'b01,
    MULT_MULHSU = 2'b10,
    MULT_MULHU  = 2'b11
  } MULT_FUNC;

  typedef struct packed {
    logic                valid;
    MULT_FUNC            func;
    logic [TAG_W-1:0]    tag;
    logic [2*XLEN-1:0]   a;
    logic [2*XLEN-1:0]   b;
    logic [2*XLEN-1:0]   sum;
  } MULT_STAGE_PACKET;

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag;
  } MULT_RESULT_PACKET;

  // A is signed for every function except MULHU.
  function automatic logic [2*XLEN-1:0] extend_a(input MULT_FUNC f, input logic [XLEN-1:0] v);
    if (f == MULT_MULHU) return {{XLEN{1'b0}}, v};
    else                 return {{XLEN{v[XLEN-1]}}, v};
  endfunction

  // B is signed only for MUL and MULH.
  function automatic logic [2*XLEN-1:0] extend_b(input MULT_FUNC f, input logic [XLEN-1:0] v);
    if (f == MULT_MUL || f == MULT_MULH) return {{XLEN{v[XLEN-1]}}, v};
    else                                 return {{XLEN{1'b0}}, v};
  endfunction

endpackage

// File: rtl/mult_stage.sv
// One combinational slice of the multiply pipeline.
//   IDX        : stage index, selects which B chunk this slice consumes
//   NUM_STAGES : total slices; the 2*XLEN-bit B is split into NUM_STAGES chunks
//   stage_pkt  : packet held in stage register IDX
//   next_pkt   : same packet with extA * chunk(IDX) << IDX*C added to sum
module mult_stage
  import sys_defs::*;
#(
  parameter int unsigned IDX        = 0,
  parameter int unsigned NUM_STAGES = 4
) (
  input  MULT_STAGE_PACKET stage_pkt,
  output MULT_STAGE_PACKET next_pkt
);

  localparam int unsigned C = 2 * XLEN / NUM_STAGES;

  logic [C-1:0]      chunk;
  logic [2*XLEN-1:0] chunk_ext;
  logic [2*XLEN-1:0] partial;

  // Chunks are taken unsigned; the sign of extB lives in its upper chunks,
  // so the sum over all chunks is exact modulo 2^(2*XLEN).
  always_comb begin
    chunk            = stage_pkt.b[IDX*C +: C];
    chunk_ext        = '0;
    chunk_ext[C-1:0] = chunk;
    partial          = stage_pkt.a * chunk_ext;
    next_pkt         = stage_pkt;
    next_pkt.sum     = stage_pkt.sum + (partial << (IDX * C));
  end

endmodule

// File: rtl/mult_fu.sv
// Pipelined RV32M multiply functional unit.
//   clock, reset (sync, active-low), flush (squash all in-flight ops)
//   in_valid/in_func/in_rs1/in_rs2/in_tag : issued multiply
//   out_valid/out_result/out_tag          : result held for CDB
//   out_ack : CDB grant;  stall : pipe cannot accept (combinational)
//   busy    : any stage or the output register holds a valid op
// NUM_STAGES must divide 2*XLEN, 2 <= NUM_STAGES <= 8.
module mult_fu
  import sys_defs::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned TAG_W      = 6,
  parameter int unsigned NUM_STAGES = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       in_func,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  input  logic             out_ack,
  output logic             stall,
  output logic             busy
);

  MULT_STAGE_PACKET  stage_q    [NUM_STAGES];
  MULT_STAGE_PACKET  stage_next [NUM_STAGES];
  MULT_STAGE_PACKET  entry;
  MULT_RESULT_PACKET out_q;
  MULT_RESULT_PACKET last;

  // Stage k's arithmetic sits between stage register k and register k+1;
  // the last slice feeds the output register directly.
  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    mult_stage #(
      .IDX        (k),
      .NUM_STAGES (NUM_STAGES)
    ) u_stage (
      .stage_pkt (stage_q[k]),
      .next_pkt  (stage_next[k])
    );
  end

  always_comb begin
    entry.valid = in_valid;
    entry.func  = MULT_FUNC'(in_func);
    entry.tag   = in_tag;
    entry.a     = extend_a(MULT_FUNC'(in_func), in_rs1);
    entry.b     = extend_b(MULT_FUNC'(in_func), in_rs2);
    entry.sum   = '0;
  end

  always_comb begin
    last.valid  = stage_next[NUM_STAGES-1].valid;
    last.tag    = stage_next[NUM_STAGES-1].tag;
    if (stage_next[NUM_STAGES-1].func == MULT_MUL)
      last.result = stage_next[NUM_STAGES-1].sum[XLEN-1:0];
    else
      last.result = stage_next[NUM_STAGES-1].sum[2*XLEN-1:XLEN];
  end

  // Operands are no longer needed once the final chunk is accumulated.
  logic unused_final_operands;
  assign unused_final_operands = ^{stage_next[NUM_STAGES-1].a, stage_next[NUM_STAGES-1].b};

  assign stall = out_q.valid & ~out_ack;

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) stage_q[k] <= '0;
      out_q <= '0;
    end else if (flush) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) stage_q[k].valid <= 1'b0;
      out_q.valid <= 1'b0;
    end else if (!stall) begin
      stage_q[0] <= entry;
      for (int unsigned k = 1; k < NUM_STAGES; k++) stage_q[k] <= stage_next[k-1];
      out_q <= last;
    end
  end

  always_comb begin
    busy = out_q.valid;
    for (int unsigned k = 0; k < NUM_STAGES; k++) busy = busy | stage_q[k].valid;
  end

  assign out_valid  = out_q.valid;
  assign out_result = out_q.result;
  assign out_tag    = out_q.tag;

endmodule

// File: tb/tb_mult_fu.sv
// Self-checking bench for mult_fu: table of single-op vectors plus
// hand-written stall, flush, reset and alternating-handshake sequences.
module tb_mult_fu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_func = 2'b00;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [5:0]  in_tag = '0;
  logic        out_valid;
  logic [31:0] out_result;
  logic [5:0]  out_tag;
  logic        out_ack = 1'b0;
  logic        stall;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mult_fu #(
    .XLEN       (32),
    .TAG_W      (6),
    .NUM_STAGES (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_func    (in_func),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_ack    (out_ack),
    .stall      (stall),
    .busy       (busy)
  );

  typedef struct {
    logic [1:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [12];
  vec_t ops  [6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] t);
    in_valid = 1'b1;
    in_func  = f;
    in_rs1   = a;
    in_rs2   = b;
    in_tag   = t;
  endtask

  // Returns how many cycles elapsed before out_valid rose (20 = never).
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Full-width reference product, independent of the chunked datapath.
  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f == 2'b11) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = f[1] ? {32'b0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int seen;
    int sent;
    int got;
    int cyc;
    logic bubble;
    logic accepted;
    logic [31:0] stall_exp [4];

    vecs[0]  = '{2'b00, 32'd3,         32'd5,         6'd7,  32'h0000000F};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  6'd8,  32'h00000000};
    vecs[2]  = '{2'b11, 32'hFFFFFFFF,  32'hFFFFFFFF,  6'd9,  32'hFFFFFFFE};
    vecs[3]  = '{2'b10, 32'hFFFFFFFF,  32'h00000002,  6'd10, 32'hFFFFFFFF};
    vecs[4]  = '{2'b00, 32'h80000000,  32'h80000000,  6'd11, 32'h00000000};
    vecs[5]  = '{2'b01, 32'h80000000,  32'h80000000,  6'd12, 32'h40000000};
    vecs[6]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF,  6'd13, 32'h80000000};
    vecs[7]  = '{2'b00, 32'd7,         32'hFFFFFFFD,  6'd14, 32'hFFFFFFEB};
    vecs[8]  = '{2'b01, 32'd7,         32'hFFFFFFFD,  6'd15, 32'hFFFFFFFF};
    vecs[9]  = '{2'b01, 32'h7FFFFFFF,  32'h7FFFFFFF,  6'd16, 32'h3FFFFFFF};
    vecs[10] = '{2'b11, 32'h00010000,  32'h00010000,  6'd17, 32'h00000001};
    vecs[11] = '{2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  6'd18, 32'h00000001};

    // Reset state
    tick();
    tick();
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_out_tag", {26'b0, out_tag}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    reset = 1'b1;
    tick();

    // Single ops with ack held high
    out_ack = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].tag);
      tick();
      in_valid = 1'b0;
      wait_out(n);
      check($sformatf("vec%0d_latency", i), n, 32'd4);
      check($sformatf("vec%0d_result", i), out_result, vecs[i].exp);
      check($sformatf("vec%0d_tag", i), {26'b0, out_tag}, {26'b0, vecs[i].tag});
      tick();
      check($sformatf("vec%0d_one_cycle", i), {31'b0, out_valid}, 32'd0);
    end

    // Back-pressure: four ops, ack held low, then drained
    stall_exp[0] = 32'h0000000F;
    stall_exp[1] = 32'h00000000;
    stall_exp[2] = 32'hFFFFFFFE;
    stall_exp[3] = 32'hFFFFFFFF;
    out_ack = 1'b0;
    drive(2'b00, 32'd3, 32'd5, 6'd1);                 tick();
    drive(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd2);   tick();
    drive(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd3);   tick();
    drive(2'b10, 32'hFFFFFFFF, 32'h00000002, 6'd4);   tick();
    in_valid = 1'b0;
    wait_out(n);
    check("stall_first_latency", n, 32'd1);
    check("stall_asserted", {31'b0, stall}, 32'd1);
    check("stall_head_tag", {26'b0, out_tag}, 32'd1);
    drive(2'b00, 32'd1, 32'd1, 6'd9);
    tick();
    tick();
    check("stall_hold_valid", {31'b0, out_valid}, 32'd1);
    check("stall_hold_tag", {26'b0, out_tag}, 32'd1);
    check("stall_hold_result", out_result, 32'h0000000F);
    in_valid = 1'b0;
    out_ack  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("drain%0d_tag", i), {26'b0, out_tag}, i + 1);
      check($sformatf("drain%0d_result", i), out_result, stall_exp[i]);
      tick();
    end
    check("drain_done_valid", {31'b0, out_valid}, 32'd0);
    check("drain_done_busy", {31'b0, busy}, 32'd0);

    // Flush with two ops in flight and a simultaneous issue
    drive(2'b00, 32'd2, 32'd3, 6'd10); tick();
    drive(2'b00, 32'd4, 32'd5, 6'd11); tick();
    drive(2'b00, 32'd6, 32'd7, 6'd12);
    flush = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    seen = 0;
    repeat (10) begin
      tick();
      if (out_valid) seen++;
    end
    check("flush_no_result", seen, 32'd0);

    // Reset mid-operation
    out_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b00, 32'd1, 32'd1, 6'(20 + i));
      tick();
    end
    in_valid = 1'b0;
    wait_out(n);
    check("midreset_pre_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    check("midreset_out_result", out_result, 32'd0);
    check("midreset_out_tag", {26'b0, out_tag}, 32'd0);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    check("midreset_stall", {31'b0, stall}, 32'd0);
    out_ack = 1'b1;
    drive(2'b00, 32'd6, 32'd7, 6'd5);
    tick();
    in_valid = 1'b0;
    wait_out(n);
    check("post_reset_latency", n, 32'd4);
    check("post_reset_result", out_result, 32'd42);
    check("post_reset_tag", {26'b0, out_tag}, 32'd5);
    tick();

    // Alternating issue/bubble with ack toggling
    ops[0] = '{2'b00, 32'd3,        32'd4,        6'd30, 32'h0};
    ops[1] = '{2'b01, 32'd7,        32'hFFFFFFFD, 6'd31, 32'h0};
    ops[2] = '{2'b11, 32'h00010000, 32'h00010000, 6'd32, 32'h0};
    ops[3] = '{2'b10, 32'hFFFFFFFF, 32'h00000002, 6'd33, 32'h0};
    ops[4] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 6'd34, 32'h0};
    ops[5] = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 6'd35, 32'h0};
    for (int i = 0; i < 6; i++) ops[i].exp = ref_mul(ops[i].func, ops[i].a, ops[i].b);
    sent   = 0;
    got    = 0;
    cyc    = 0;
    bubble = 1'b0;
    while (got < 6 && cyc < 100) begin
      out_ack = (cyc % 2 == 0);
      if (sent < 6 && !bubble) drive(ops[sent].func, ops[sent].a, ops[sent].b, ops[sent].tag);
      else in_valid = 1'b0;
      #1;
      if (out_valid && out_ack) begin
        check($sformatf("alt%0d_tag", got), {26'b0, out_tag}, {26'b0, ops[got].tag});
        check($sformatf("alt%0d_result", got), out_result, ops[got].exp);
        got++;
      end
      accepted = in_valid && !stall;
      tick();
      if (accepted) begin
        sent++;
        bubble = 1'b1;
      end else if (!in_valid) begin
        bubble = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("alt_count", got, 32'd6);
    out_ack = 1'b1;
    seen = 0;
    repeat (8) begin
      tick();
      if (out_valid) seen++;
    end
    check("alt_no_extra", seen, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_fu.md
Name: mult_fu

Overview:
- Pipelined integer multiply functional unit, directly downstream of the issue stage.
- Consumes the register-read operands and destination tag of each issued multiply, computes the RV32M product over NUM_STAGES cycles, and presents a completed result to CDB arbitration with a valid/ack handshake.
- Drives the per-FU stall bit back to issue so that no multiply is issued into a full, blocked pipe.

Parameters:
- XLEN, 32, operand and result width.
- TAG_W, 6, physical register tag width (matches PHYS_REG_IDX).
- NUM_STAGES, 4, pipeline depth; must divide 2*XLEN evenly, with 2 <= NUM_STAGES <= 8.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset; asserted when 0
- flush  in  1  mispredict squash; kills all in-flight ops
- in_valid  in  1  issued multiply present this cycle
- in_func  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- in_rs1  in  XLEN  operand A
- in_rs2  in  XLEN  operand B
- in_tag  in  TAG_W  destination physical register
- out_valid  out  1  result held for CDB
- out_result  out  XLEN  result value
- out_tag  out  TAG_W  destination tag of result
- out_ack  in  1  CDB grant; result consumed this cycle
- stall  out  1  pipe cannot accept; combinational
- busy  out  1  any stage holds a valid op

Behaviour:
- Reset (reset==0 at posedge): all stage valid bits cleared, out_valid=0, out_result=0, out_tag=0. stall=0 and busy=0 follow on the next evaluation. Reset overrides flush, in_valid and out_ack, including mid-operation.
- Operand extension at accept:
  - A is sign-extended for MUL, MULH and MULHSU; zero-extended for MULHU.
  - B is sign-extended for MUL and MULH; zero-extended for MULHSU and MULHU.
  - Both are carried as 2*XLEN-bit values.
- Arithmetic:
  - Let P be the low 2*XLEN bits of extA*extB.
  - Stage k (0-based) adds extA times B-chunk k, shifted left by k*(2*XLEN/NUM_STAGES), into the running sum. The chunk is bits [(k+1)*C-1 : k*C] of extB, with C=2*XLEN/NUM_STAGES.
  - MUL returns P[XLEN-1:0]. The other funcs return P[2*XLEN-1:XLEN].
- Per-stage register contents: valid, func, tag, extA, extB, partial sum.
- Latency: an op accepted at posedge t, with no stall, has out_valid=1 from posedge t+NUM_STAGES.
- Handshake:
  - stall = out_valid & ~out_ack.
  - While stall=1, every stage holds its value.
  - When stall=0, all stages advance one position and stage 0 captures in_valid.
  - in_valid with stall=1 is not accepted; issue must hold the op and re-present it.
  - Bubbles advance normally. There is no bubble collapse.
- Output: when stall=0, the last stage's value is registered into out_*. out_valid deasserts the cycle after ack unless a new result arrives, so back-to-back results are allowed on consecutive acks.
- Flush (reset deasserted): all stage valid bits and out_valid are cleared at the next posedge. An in_valid in the same cycle is discarded. An out_ack in the same cycle is still honoured as a completed transfer by the CDB, since out_valid was high.
- busy = OR of all stage valid bits and out_valid.
- Out-of-range func cannot occur: all four 2-bit codes are defined.

Decomposition:
- Shared package (sys_defs):
  - MULT_FUNC enum (2 bits).
  - MULT_STAGE_PACKET struct: valid, func, tag, a, b, sum.
  - MULT_RESULT_PACKET struct: valid, result, tag.
- Sub-module mult_stage, instantiated NUM_STAGES times via generate:
  - Purely combinational.
  - Takes a MULT_STAGE_PACKET and a stage index.
  - Returns the packet with the chunk product accumulated.
- mult_fu owns the stage registers, handshake and flush logic.

Test Plan:
- MUL 3*5, tag 7, ack held 1 -> out_valid exactly 4 cycles after accept, result 0x0000000F, tag 7, one cycle wide.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000. MULHU same operands -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF. MUL 0x80000000*0x80000000 -> 0x00000000.
- Four ops issued on consecutive cycles (tags 1-4), out_ack low once the first result appears:
  - stall=1 and pipe frozen.
  - New in_valid ignored.
  - Raise ack for 4 cycles -> tags 1,2,3,4 emerge in order on consecutive cycles with correct products.
- Two ops in flight, flush pulsed 1 cycle with a simultaneous in_valid -> next cycle busy=0, out_valid=0, and no result ever appears for any of the three ops.
- reset=0 for 1 cycle while 3 ops are in flight and out_valid=1 -> next cycle all outputs 0, busy=0, stall=0. An op issued right after reset completes normally.
- Alternating valid/bubble issue with ack toggling 1,0,1,0 -> no result lost or duplicated, and no bubble emitted as out_valid=1.
